div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 SHALL have port rs1  input  XLEN  dividend, sampled with start.
REQ-007 SHALL have port rs2  input  XLEN  divisor, sampled with start.
REQ-008 SHALL have port flush  input  1  abort in-flight operation (branch/trap kill).
REQ-009 SHALL have port busy  output  1  high in CALC and FIX; EX stage stalls on it.
REQ-010 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port result  output  XLEN  quotient or remainder, muxed with ALU result into EX/MEM.

Function
REQ-012 SHALL implement states IDLE, CALC, FIX, DONE.
REQ-013 SHALL, in IDLE with start=1 and flush=0, latch op, |rs1|, |rs2| (signed ops) or raw (unsigned ops), and the sign flags.
REQ-014 SHALL go IDLE->CALC on normal start, with a 5-bit iteration counter cleared.
REQ-015 SHALL perform one restoring radix-2 step per CALC cycle, 32 cycles, on a 33-bit partial remainder.
REQ-016 SHALL go CALC->FIX after the 32nd step, and FIX->DONE after one cycle.
REQ-017 SHALL, in FIX, negate the quotient when DIV and operand signs differ, negate the remainder when REM and the dividend is negative, and register result.
REQ-018 SHALL assert done only in DONE, then go DONE->IDLE unconditionally; start is not accepted in DONE.
REQ-019 SHALL give latency for start in cycle 0: done=1 in cycle 34.
REQ-020 SHALL fast-path rs2==0 by going IDLE->DONE with DIV/DIVU = all ones and REM/REMU = rs1; done=1 in cycle 1.
REQ-021 SHALL fast-path DIV/REM overflow (rs1=0x80000000, rs2=0xFFFFFFFF) by going IDLE->DONE with DIV = 0x80000000 and REM = 0; done=1 in cycle 1.
REQ-022 SHALL ignore start while not in IDLE.
REQ-023 SHALL force the next state to IDLE from any state on flush=1, with no done and result unchanged.
REQ-024 SHALL let flush win when start and flush are high in the same cycle.
REQ-025 SHALL hold result stable from DONE until the next FIX or fast-path load.
REQ-026 SHALL have busy combinational from state only, with no path from start.

Reset
REQ-027 SHALL, on rst=0, immediately set state IDLE, busy=0, done=0, result=0, counter=0 and datapath registers=0, including mid-operation.
REQ-028 SHALL, after rst deasserts, accept a start in the first clk cycle.

Structure
REQ-029 SHALL define the op encoding enum and the state enum in the shared CPU package, next to the ALU op codes.
REQ-030 SHALL be a single module with no sub-module; the iteration step is inline logic.

Verification
REQ-031 SHALL cover DIVU 100/7, start cycle 0 -> busy cycles 1-33, done cycle 34, result 14; REMU same -> 2.
REQ-032 SHALL cover DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; REM 7/0xFFFFFFFE -> 1.
REQ-033 SHALL cover DIVU 5/0 -> done cycle 1, 0xFFFFFFFF; REMU 5/0 -> 5.
REQ-034 SHALL cover DIV 0x80000000/0xFFFFFFFF -> done cycle 1, 0x80000000; REM same -> 0.
REQ-035 SHALL cover flush in cycle 10 of CALC -> busy=0 next cycle, no done; start DIVU 9/3 next cycle -> 3 in cycle 34.
REQ-036 SHALL cover rst=0 mid-CALC, asynchronous to clk -> busy/done/result=0 with no clock edge; start after release completes normally.

Source files
------------

// File: rtl/div_unit_pkg.sv
// ============================================================================
// div_unit_pkg: shared CPU encodings (ALU ops, divider ops, divider states).
// Revision: 1.0
// ============================================================================
`default_nettype none

package div_unit_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_CALC = 2'b01,
        DIV_FIX  = 2'b10,
        DIV_DONE = 2'b11
    } div_state_e;

endpackage

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
// div_unit: iterative restoring radix-2 divider (DIV/DIVU/REM/REMU) with
//           fast paths for divide-by-zero and signed overflow.
// Revision: 1.0
// ============================================================================
`default_nettype none

module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST_STEP = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state;
    div_state_e      state_nx;
    div_op_e         op_q;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] dvsr;
    logic            neg_q;
    logic            neg_r;

    logic            is_signed;
    logic            is_rem;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            div_zero;
    logic            ovf;
    logic            accept;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            q_is_rem;

    assign is_signed = ~op[0];
    assign is_rem    = op[1];
    assign a_neg     = is_signed & rs1[XLEN-1];
    assign b_neg     = is_signed & rs2[XLEN-1];
    assign abs_a     = a_neg ? -rs1 : rs1;
    assign abs_b     = b_neg ? -rs2 : rs2;
    assign div_zero  = (rs2 == '0);
    assign ovf       = is_signed & (rs1 == INT_MIN) & (rs2 == '1);
    assign accept    = (state == DIV_IDLE) & start & ~flush;

    // Restoring step: bring in the next dividend bit, keep the difference if it did not go negative.
    assign shifted   = {rem, quo[XLEN-1]};
    assign diff      = shifted - {1'b0, dvsr};
    assign q_is_rem  = (op_q == DIV_OP_REM) || (op_q == DIV_OP_REMU);

    assign busy = (state == DIV_CALC) || (state == DIV_FIX);
    assign done = (state == DIV_DONE);

    always_comb begin
        state_nx = state;
        case (state)
            DIV_IDLE: if (accept) state_nx = (div_zero || ovf) ? DIV_DONE : DIV_CALC;
            DIV_CALC: if (cnt == LAST_STEP) state_nx = DIV_FIX;
            DIV_FIX:  state_nx = DIV_DONE;
            DIV_DONE: state_nx = DIV_IDLE;
            default:  state_nx = DIV_IDLE;
        endcase
        if (flush) state_nx = DIV_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= DIV_IDLE;
            op_q   <= DIV_OP_DIV;
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q  <= div_op_e'(op);
                cnt   <= '0;
                rem   <= '0;
                quo   <= abs_a;
                dvsr  <= abs_b;
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
                if (div_zero)
                    result <= is_rem ? rs1 : '1;
                else if (ovf)
                    result <= is_rem ? '0 : INT_MIN;
            end else if (!flush) begin
                if (state == DIV_CALC) begin
                    cnt <= cnt + 1'b1;
                    if (!diff[XLEN]) begin
                        rem <= diff[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b1};
                    end else begin
                        rem <= shifted[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b0};
                    end
                end else if (state == DIV_FIX) begin
                    if (q_is_rem)
                        result <= neg_r ? -rem : rem;
                    else
                        result <= neg_q ? -quo : quo;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// tb_div_unit: directed self-checking bench for div_unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    div_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    // Issues one start in "cycle 0" and reports the cycle of done plus the busy window.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res,
                         output int bfirst, output int blast);
        lat = -1; bfirst = -1; blast = -1; res = 'x;
        @(negedge clk);
        op = o; rs1 = a; rs2 = b; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (busy) begin
                if (bfirst < 0) bfirst = n;
                blast = n;
            end
            if (done) begin
                lat = n;
                res = result;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #2 rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", result); end
        @(posedge clk); #1 rst = 1'b1;
    endtask

    task automatic test_unsigned;
        int lat, bf, bl; logic [31:0] res;
        do_op(2'b01, 32'd100, 32'd7, lat, res, bf, bl);
        checks++; if (lat !== 34) begin errors++; $display("FAIL divu_latency: got %0d expected 34", lat); end
        checks++; if (bf !== 1 || bl !== 33) begin errors++; $display("FAIL divu_busy_window: got %0d-%0d expected 1-33", bf, bl); end
        checks++; if (res !== 32'd14) begin errors++; $display("FAIL divu_100_7: got %h expected 0000000e", res); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || result !== 32'd14) begin errors++; $display("FAIL divu_hold: got done=%b result=%h expected done=0 result=0000000e", done, result); end
        do_op(2'b11, 32'd100, 32'd7, lat, res, bf, bl);
        checks++; if (lat !== 34 || res !== 32'd2) begin errors++; $display("FAIL remu_100_7: got lat=%0d res=%h expected lat=34 res=00000002", lat, res); end
    endtask

    task automatic test_signed;
        int lat, bf, bl; logic [31:0] res;
        do_op(2'b00, 32'hFFFFFFF9, 32'd2, lat, res, bf, bl);
        checks++; if (lat !== 34 || res !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg7_2: got lat=%0d res=%h expected lat=34 res=fffffffd", lat, res); end
        do_op(2'b10, 32'hFFFFFFF9, 32'd2, lat, res, bf, bl);
        checks++; if (res !== 32'hFFFFFFFF) begin errors++; $display("FAIL rem_neg7_2: got %h expected ffffffff", res); end
        do_op(2'b10, 32'd7, 32'hFFFFFFFE, lat, res, bf, bl);
        checks++; if (res !== 32'd1) begin errors++; $display("FAIL rem_7_neg2: got %h expected 00000001", res); end
        do_op(2'b00, 32'd7, 32'hFFFFFFFE, lat, res, bf, bl);
        checks++; if (res !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_7_neg2: got %h expected fffffffd", res); end
    endtask

    task automatic test_div_zero;
        int lat, bf, bl; logic [31:0] res;
        do_op(2'b01, 32'd5, 32'd0, lat, res, bf, bl);
        checks++; if (lat !== 1 || res !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu_by_zero: got lat=%0d res=%h expected lat=1 res=ffffffff", lat, res); end
        do_op(2'b11, 32'd5, 32'd0, lat, res, bf, bl);
        checks++; if (lat !== 1 || res !== 32'd5) begin errors++; $display("FAIL remu_by_zero: got lat=%0d res=%h expected lat=1 res=00000005", lat, res); end
        do_op(2'b00, 32'hFFFFFFF9, 32'd0, lat, res, bf, bl);
        checks++; if (lat !== 1 || res !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_by_zero: got lat=%0d res=%h expected lat=1 res=ffffffff", lat, res); end
    endtask

    task automatic test_overflow;
        int lat, bf, bl; logic [31:0] res;
        do_op(2'b00, 32'h80000000, 32'hFFFFFFFF, lat, res, bf, bl);
        checks++; if (lat !== 1 || res !== 32'h80000000) begin errors++; $display("FAIL div_overflow: got lat=%0d res=%h expected lat=1 res=80000000", lat, res); end
        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, lat, res, bf, bl);
        checks++; if (lat !== 1 || res !== 32'h0) begin errors++; $display("FAIL rem_overflow: got lat=%0d res=%h expected lat=1 res=00000000", lat, res); end
        do_op(2'b01, 32'h80000000, 32'hFFFFFFFF, lat, res, bf, bl);
        checks++; if (lat !== 34 || res !== 32'h0) begin errors++; $display("FAIL divu_no_overflow: got lat=%0d res=%h expected lat=34 res=00000000", lat, res); end
    endtask

    task automatic test_flush;
        int lat; logic [31:0] prev;
        bit saw_done;
        // Simultaneous start+flush on a divide-by-zero must not produce done.
        @(negedge clk);
        op = 2'b01; rs1 = 32'd5; rs2 = 32'd0; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_wins_start: got done=%b busy=%b expected 0 0", done, busy); end
        // Flush in cycle 10 of CALC.
        prev = result;
        op = 2'b01; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        saw_done = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0 || saw_done) begin errors++; $display("FAIL flush_calc: got busy=%b done=%b early_done=%b expected 0 0 0", busy, done, saw_done); end
        checks++; if (result !== prev) begin errors++; $display("FAIL flush_result_hold: got %h expected %h", result, prev); end
        op = 2'b01; rs1 = 32'd9; rs2 = 32'd3; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (done) begin lat = n; break; end
        end
        checks++; if (lat !== 34 || result !== 32'd3) begin errors++; $display("FAIL after_flush_divu_9_3: got lat=%0d res=%h expected lat=34 res=00000003", lat, result); end
    endtask

    task automatic test_ignore_start;
        int lat;
        @(negedge clk);
        op = 2'b01; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (n == 5) begin op = 2'b01; rs1 = 32'd50; rs2 = 32'd0; start = 1'b1; end
            else start = 1'b0;
            if (done) begin lat = n; break; end
        end
        start = 1'b0;
        checks++; if (lat !== 34 || result !== 32'd14) begin errors++; $display("FAIL start_ignored_busy: got lat=%0d res=%h expected lat=34 res=0000000e", lat, result); end
    endtask

    task automatic test_async_reset;
        int lat, bf, bl; logic [31:0] res;
        @(negedge clk);
        op = 2'b01; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int n = 1; n <= 10; n++) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin errors++; $display("FAIL async_reset: got busy=%b done=%b result=%h expected 0 0 00000000", busy, done, result); end
        @(posedge clk); #1 rst = 1'b1;
        do_op(2'b01, 32'hFFFFFFFF, 32'h10, lat, res, bf, bl);
        checks++; if (lat !== 34 || res !== 32'h0FFFFFFF) begin errors++; $display("FAIL post_reset_divu: got lat=%0d res=%h expected lat=34 res=0fffffff", lat, res); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_flush();
        test_ignore_start();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
